// File: rtl/p_hit_sched.sv
// p_hit_sched: round-robin scheduler sharing one fixed-latency p_hit pipeline
// among N_REQ requesters, with result tag realignment and result-buffer credits.
module p_hit_sched #(
   parameter int N_REQ   = 4,
   parameter int LAT     = 8,
   parameter int CREDITS = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     en,
   input  logic [N_REQ-1:0]         req_empty,
   output logic [N_REQ-1:0]         req_rd_en,
   output logic                     dp_in_valid,
   output logic [$clog2(N_REQ)-1:0] dp_sel,
   output logic                     out_valid,
   output logic [$clog2(N_REQ)-1:0] out_tag,
   input  logic                     buf_rd_en,
   output logic [3:0]               credits,
   output logic                     busy
);

   localparam int         SW       = $clog2(N_REQ);
   localparam int         CW       = $clog2(LAT + 2) + 1;
   localparam logic [3:0] CRED_MAX = 4'(CREDITS);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_t;

   state_t         state, state_nxt;
   logic [SW-1:0]  rr_ptr;
   logic [SW-1:0]  grant_idx;
   logic [SW-1:0]  cand;
   logic           grant_found;
   logic           issue;
   logic [LAT-1:0] sr_valid;
   logic [SW-1:0]  sr_tag [LAT];
   logic [CW-1:0]  in_flight, in_flight_nxt;

   // Search starts one past the last grant; the wrap is free since N_REQ is a power of two.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int unsigned i = 1; i <= N_REQ; i++) begin
         cand = rr_ptr + SW'(i);
         if (!grant_found && !req_empty[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   always_comb begin
      issue     = !reset && en && (credits != '0) && grant_found;
      req_rd_en = '0;
      if (issue) begin
         req_rd_en[grant_idx] = 1'b1;
      end
   end

   assign out_valid = sr_valid[LAT-1];
   assign out_tag   = sr_tag[LAT-1];
   assign busy      = (state != IDLE);

   always_comb begin
      in_flight_nxt = in_flight;
      if (dp_in_valid && !out_valid) begin
         in_flight_nxt = in_flight + CW'(1);
      end else if (!dp_in_valid && out_valid) begin
         in_flight_nxt = in_flight - CW'(1);
      end
   end

   // Leaving for IDLE is decided on the cycle the last result retires.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (issue) state_nxt = RUN;
         end
         RUN: begin
            if (!issue) begin
               state_nxt = (in_flight_nxt == '0) ? IDLE : DRAIN;
            end
         end
         DRAIN: begin
            if (issue) begin
               state_nxt = RUN;
            end else if (in_flight_nxt == '0) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         rr_ptr      <= SW'(N_REQ - 1);
         dp_in_valid <= 1'b0;
         dp_sel      <= '0;
         credits     <= CRED_MAX;
         in_flight   <= '0;
         sr_valid    <= '0;
         for (int unsigned i = 0; i < LAT; i++) begin
            sr_tag[i] <= '0;
         end
      end else begin
         state       <= state_nxt;
         in_flight   <= in_flight_nxt;
         dp_in_valid <= issue;
         if (issue) begin
            rr_ptr <= grant_idx;
            dp_sel <= grant_idx;
         end
         if (issue && !buf_rd_en) begin
            credits <= credits - 4'd1;
         end else if (!issue && buf_rd_en && (credits != CRED_MAX)) begin
            credits <= credits + 4'd1;
         end
         sr_valid[0] <= dp_in_valid;
         sr_tag[0]   <= dp_sel;
         for (int unsigned i = 1; i < LAT; i++) begin
            sr_valid[i] <= sr_valid[i-1];
            sr_tag[i]   <= sr_tag[i-1];
         end
      end
   end

endmodule

// File: doc/p_hit_sched.md
Name: p_hit_sched

Overview:
- Round-robin scheduler that shares one fixed-latency p_hit intersection pipeline among N_REQ ray requesters.
- Each requester presents a first-word-fall-through request FIFO. The scheduler pops one request per cycle, steers the pipeline input mux, and tags every job with its requester index.
- The tag is re-emitted aligned with the pipeline result. Downstream result-buffer occupancy is tracked with a credit counter so the result buffer can never overflow.

Parameters:
- N_REQ, 4, number of requesters (power of two, 2..8)
- LAT, 8, p_hit pipeline latency in cycles from dp_in_valid to result valid (1..32)
- CREDITS, 8, entries in the downstream result buffer (1..15)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  issue enable; 0 stops new issues, in-flight jobs drain
- req_empty  in  N_REQ  per-requester FIFO empty flag
- req_rd_en  out  N_REQ  one-hot pop strobe to the granted requester FIFO
- dp_in_valid  out  1  pipeline input valid, one cycle after req_rd_en
- dp_sel  out  log2(N_REQ)  pipeline input mux select, valid with dp_in_valid
- out_valid  out  1  result at pipeline output belongs to out_tag; write strobe to result buffer
- out_tag  out  log2(N_REQ)  requester index of the current result
- buf_rd_en  in  1  downstream pop of the result buffer; returns one credit
- credits  out  4  available credits
- busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, immediate):
  - outputs: req_rd_en=0, dp_in_valid=0, dp_sel=0, out_valid=0, out_tag=0, credits=CREDITS, busy=0
  - internal: rr_ptr=N_REQ-1 (requester 0 has first priority), tag/valid shift register cleared, state=IDLE
- Reset mid-operation discards all in-flight tags. No out_valid follows reset, even if the pipeline still emits data.
- Grant condition, evaluated each cycle:
  - issue = en && credits_avail>0 && |(~req_empty)
  - the granted requester is the first non-empty index searching rr_ptr+1, rr_ptr+2, ... with modulo N_REQ wrap
  - on grant: req_rd_en[g]=1 (combinational from registered state and inputs), rr_ptr<=g
  - at most one grant per cycle
- Issue pipeline:
  - cycle T: req_rd_en
  - cycle T+1: dp_in_valid=1, dp_sel=g (registered)
  - cycle T+1+LAT: out_valid=1, out_tag=g
  - LAT-deep shift register carries {valid, tag}. Back-to-back issues produce back-to-back results in issue order.
- Credits:
  - decrement on issue (reservation at grant time), increment on buf_rd_en
  - issue and buf_rd_en in the same cycle: no change
  - buf_rd_en when credits==CREDITS: ignored, saturates
  - credits==0: no grant until a buf_rd_en; req_rd_en may reassert in the cycle after the pop
- Fairness: with all requesters continuously non-empty, grants rotate 0,1,2,3,0,... One grant per cycle while credits last.
- State machine:
  - IDLE -> RUN when issue is true
  - RUN -> DRAIN when en=0 or no grant is possible, with jobs in flight
  - RUN -> IDLE when no grant, zero jobs in flight, and no dp_in_valid
  - DRAIN -> RUN when issue becomes true
  - DRAIN -> IDLE when the shift register is empty and dp_in_valid=0
  - busy=1 in RUN and DRAIN
- Jobs in flight: a counter of width log2(LAT+2)+1 counts dp_in_valid entries not yet retired by out_valid. Increment and retire in the same cycle leave it unchanged.
- req_empty sampled high for a requester is never granted. Popping an empty FIFO is a bench error.

Test Plan:
- Single request: after reset, en=1, req_empty=4'b1011 -> req_rd_en=4'b0100 at cycle 1; dp_in_valid with dp_sel=2 at cycle 2; out_valid with out_tag=2 at cycle 2+LAT=10; credits 8->7; busy returns to 0 after cycle 10.
- Round-robin saturation: all requesters non-empty, buf_rd_en held 1 -> grants 0,1,2,3,0,1,... every cycle; out_tag sequence matches, delayed LAT+1 cycles; credits steady at 8 after the first cycle.
- Credit exhaustion: CREDITS=8, no buf_rd_en, all requesters non-empty -> exactly 8 grants, credits=0, req_rd_en=0. One buf_rd_en pulse -> exactly one further grant the next cycle.
- Simultaneous events: credits=3, issue and buf_rd_en in the same cycle -> credits stays 3. buf_rd_en at credits=8 -> remains 8.
- Enable drop: en deasserted after 5 issues -> no further req_rd_en; state DRAIN; all 5 out_valid pulses still appear; IDLE one cycle after the last out_valid.
- Async reset mid-flight: assert reset between clock edges with 4 jobs in flight -> outputs clear immediately; no out_valid afterwards; credits=8; next grant goes to requester 0.
